data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate L1 data cache between the MEM pipeline stage and the line-wide data memory. Serves load hits combinationally with no stall. On a load miss it stalls the pipeline, requests the full 16-word (512-bit) line, and waits for the memory's level READY. It then fills the line and releases the stall. Stores are forwarded to memory every time and also update the cached word on a hit.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_line_store.sv | 52 +++++
 rtl/data_cache.sv | 93 +++++++++
 tb/tb_data_cache.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants, FSM state encodings and address-field helpers for data_cache.
package dcache_pkg;

  localparam int LINE_W      = 512;
  localparam int WORD_W      = 32;
  localparam int OFFSET_BITS = 4;
  localparam int BYTE_BITS   = 2;
  localparam int LINE_SHIFT  = OFFSET_BITS + BYTE_BITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] FILL = 2'd3;

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned ib);
    return (a >> LINE_SHIFT) & ((32'd1 << ib) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned ib);
    return a >> (LINE_SHIFT + ib);
  endfunction

  function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [31:0] a);
    return a[LINE_SHIFT-1:BYTE_BITS];
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: combinational lookup, whole-line fill and single-word write.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 32 - 6 - INDEX_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_BITS-1:0]  idx,
  input  logic [TAG_BITS-1:0]    tag,
  input  logic [OFFSET_BITS-1:0] off,
  input  logic                   fill_en,
  input  logic [LINE_W-1:0]      fill_line,
  input  logic                   wr_en,
  input  logic [WORD_W-1:0]      wr_word,
  output logic                   hit,
  output logic [WORD_W-1:0]      word
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [LINE_W-1:0]   data [LINES];
  logic [LINE_W-1:0]   cur_line;
  logic [8:0]          bit_pos;

  assign bit_pos  = {off, 5'd0};
  assign cur_line = data[idx];
  assign hit      = valid[idx] && (tags[idx] == tag);
  assign word     = cur_line[bit_pos +: WORD_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
    end
  end

  // Tag/data contents are don't-care until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data[idx] <= fill_line;
      tags[idx] <= tag;
    end else if (wr_en) begin
      data[idx][bit_pos +: WORD_W] <= wr_word;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate L1 data cache.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module data_cache
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 32 - 6 - INDEX_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic              stall,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wd,
  input  logic              mem_ready,
`ifdef DCACHE_STATS_EN
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
`endif
  input  logic [LINE_W-1:0] mem_rd
);

  logic [1:0]            state, state_nx;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [WORD_W-1:0]     word;
  logic                  hit, idle, load;

  assign idx  = INDEX_BITS'(addr_index(addr, INDEX_BITS));
  assign tag  = TAG_BITS'(addr_tag(addr, INDEX_BITS));
  assign idle = (state == IDLE);
  assign load = re && !we;

  dcache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .tag       (tag),
    .off       (addr_offset(addr)),
    .fill_en   (state == FILL),
    .fill_line (mem_rd),
    .wr_en     (idle && we && hit),
    .wr_word   (wd),
    .hit       (hit),
    .word      (word)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load && !hit) state_nx = ARM;
      // A READY still high from the previous fill must drop before a new one counts.
      ARM:     if (!mem_ready)   state_nx = WAIT;
      WAIT:    if (mem_ready)    state_nx = FILL;
      FILL:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign stall    = idle ? (load && !hit) : 1'b1;
  assign mem_re   = stall;
  assign mem_we   = idle && we;
  assign mem_addr = addr;
  assign mem_wd   = wd;
  assign rd       = (idle && load && hit) ? word : '0;

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (idle && load) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: vector table, load scoreboard, reset-mid-miss sequence.
module tb_data_cache;

  localparam int LAT = 20;

  typedef struct {
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_miss;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         re = 1'b0, we = 1'b0;
  logic [31:0]  addr = '0, wd = '0;
  logic [31:0]  rd, mem_addr, mem_wd;
  logic         stall, mem_re, mem_we;
  logic         mem_ready;
  logic [511:0] mem_rd;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  logic [31:0]  mem [0:4095];
  int unsigned  lat, hold;
  int           n_cmp = 0, n_bad = 0;
  logic [31:0]  sb [$];
  vec_t         vecs [12];

  always #5 clk = ~clk;

  data_cache #(.INDEX_BITS(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .re        (re),
    .we        (we),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd),
    .stall     (stall),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_ready (mem_ready),
`ifdef DCACHE_STATS_EN
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
`endif
    .mem_rd    (mem_rd)
  );

  // Line-wide memory: word i initialised to A5000000|i, word 0x10 = DEADBEEF.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | i;
    mem[16] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr[13:2]] = mem_wd;
    end
  end

  always_comb begin
    mem_rd = '0;
    for (int k = 0; k < 16; k++) mem_rd[k*32 +: 32] = mem[{mem_addr[13:6], k[3:0]}];
  end

  // READY rises LAT cycles into a request and lingers two cycles after mem_re drops.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready <= 1'b0; lat <= 0; hold <= 0;
    end else if (hold != 0) begin
      hold <= hold - 1;
      if (hold == 1) mem_ready <= 1'b0;
    end else if (mem_ready) begin
      if (!mem_re) hold <= 2;
    end else if (mem_re) begin
      if (lat == LAT - 1) begin mem_ready <= 1'b1; lat <= 0; end
      else lat <= lat + 1;
    end else begin
      lat <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic saw_stall, re_ok, done;
    @(posedge clk); #1;
    addr = v.addr; wd = v.wd;
    if (v.is_store) begin
      we = 1'b1; re = 1'b0;
      @(negedge clk);
      check("store_mem_we", {31'd0, mem_we}, 32'd1);
      check("store_no_stall", {31'd0, stall}, 32'd0);
      check("store_mem_wd", mem_wd, v.wd);
      @(posedge clk); #1 we = 1'b0;
    end else begin
      re = 1'b1; we = 1'b0;
      sb.push_back(v.exp_rd);
      saw_stall = 1'b0; re_ok = 1'b1; done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        if (stall) begin
          saw_stall = 1'b1;
          if (!mem_re) re_ok = 1'b0;
        end else begin
          done = 1'b1;
          if (sb.size() == 0) check("load_sb_empty", 32'd1, 32'd0);
          else check("load_rd", rd, sb.pop_front());
        end
      end
      if (!done) begin
        check("load_timeout", 32'd1, 32'd0);
        sb.delete();
      end
      check("load_miss_seen", {31'd0, saw_stall}, {31'd0, v.exp_miss});
      if (v.exp_miss) check("mem_re_held", {31'd0, re_ok}, 32'd1);
      @(posedge clk); #1 re = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h0040, 32'h0, 32'hDEAD_BEEF, 1'b1};
    vecs[1]  = '{1'b0, 32'h0044, 32'h0, 32'hA500_0011, 1'b0};
    vecs[2]  = '{1'b1, 32'h0048, 32'h1234_5678, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0048, 32'h0, 32'h1234_5678, 1'b0};
    vecs[4]  = '{1'b1, 32'h2000, 32'hCAFE_F00D, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h2000, 32'h0, 32'hCAFE_F00D, 1'b1};
    vecs[6]  = '{1'b0, 32'h007C, 32'h0, 32'hA500_001F, 1'b0};
    vecs[7]  = '{1'b0, 32'h1040, 32'h0, 32'hA500_0410, 1'b1};
    vecs[8]  = '{1'b0, 32'h0040, 32'h0, 32'hDEAD_BEEF, 1'b1};
    vecs[9]  = '{1'b0, 32'h1044, 32'h0, 32'hA500_0411, 1'b1};
    vecs[10] = '{1'b0, 32'h0048, 32'h0, 32'h1234_5678, 1'b1};
    vecs[11] = '{1'b0, 32'h0000, 32'h0, 32'hA500_0000, 1'b1};

    #3;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_mem_re", {31'd0, mem_re}, 32'd0);
    check("reset_mem_we", {31'd0, mem_we}, 32'd0);
    check("reset_rd", rd, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset while the miss to 0x3000 sits in WAIT.
    @(posedge clk); #1;
    addr = 32'h3000; re = 1'b1;
    repeat (8) @(negedge clk);
    check("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1; re = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_mem_re", {31'd0, mem_re}, 32'd0);
    check("mid_rst_rd", rd, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_vec('{1'b0, 32'h0040, 32'h0, 32'hDEAD_BEEF, 1'b1});

`ifdef DCACHE_STATS_EN
    check("hit_cnt", hit_cnt, 32'd1);
    check("miss_cnt", miss_cnt, 32'd1);
`endif
    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
